// File: rtl/stream_mux_n.sv
// N-channel registered stream mux with packet-atomic channel lock.
// Define RR_ARB_EN to replace sel with round-robin arbitration in IDLE.
module stream_mux_n #(
   parameter int W  = 8,
   parameter int N  = 4,
   parameter int SW = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [SW-1:0]   sel,
   input  logic [N*W-1:0]  in_data,
   input  logic [N-1:0]    in_valid,
   input  logic [N-1:0]    in_last,
   output logic [N-1:0]    in_ready,
   output logic [W-1:0]    out_data,
   output logic            out_valid,
   output logic            out_last,
   input  logic            out_ready,
   output logic [SW-1:0]   cur_sel
);

   localparam logic [0:0] S_IDLE   = 1'b0;
   localparam logic [0:0] S_LOCKED = 1'b1;

   logic [0:0]    r_state;
   logic [SW-1:0] r_lock_ch;
   logic [W-1:0]  r_data;
   logic          r_valid;
   logic          r_last;

   logic [SW-1:0] w_g;
   logic          w_grant;
   logic          w_space;
   logic          w_accept;
   logic          w_vld_g;
   logic          w_last_g;
   logic [W-1:0]  w_data_g;
   logic [N-1:0]  w_ready;

`ifdef RR_ARB_EN
   logic [SW-1:0] w_rr_ch;
   logic          w_rr_hit;
   int unsigned   w_best;
   int unsigned   w_dist;
   logic          w_unused;

   assign w_unused = ^sel;

   // Channels are ranked by distance from the one after lock_ch.
   always_comb begin
      w_rr_ch  = '0;
      w_rr_hit = 1'b0;
      w_best   = N;
      w_dist   = 0;
      for (int unsigned j = 0; j < N; j++) begin
         w_dist = (j + 2 * N - 32'(r_lock_ch) - 1) % N;
         if (in_valid[j] && w_dist < w_best) begin
            w_best   = w_dist;
            w_rr_ch  = SW'(j);
            w_rr_hit = 1'b1;
         end
      end
   end

   always_comb begin
      if (r_state == S_LOCKED) begin
         w_g     = r_lock_ch;
         w_grant = 32'(r_lock_ch) < N;
      end else begin
         w_g     = w_rr_ch;
         w_grant = w_rr_hit;
      end
   end
`else
   always_comb begin
      w_g     = (r_state == S_LOCKED) ? r_lock_ch : sel;
      w_grant = 32'(w_g) < N;
   end
`endif

   assign w_space = !r_valid || out_ready;

   always_comb begin
      w_ready  = '0;
      w_vld_g  = 1'b0;
      w_last_g = 1'b0;
      w_data_g = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (w_grant && 32'(w_g) == i) begin
            w_ready[i] = w_space;
            w_vld_g    = in_valid[i];
            w_last_g   = in_last[i];
            w_data_g   = in_data[i*W +: W];
         end
      end
   end

   assign w_accept = w_grant && w_space && w_vld_g;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_lock_ch <= '0;
         r_data    <= '0;
         r_valid   <= 1'b0;
         r_last    <= 1'b0;
      end else if (w_accept) begin
         r_data    <= w_data_g;
         r_last    <= w_last_g;
         r_valid   <= 1'b1;
         r_lock_ch <= w_g;
         r_state   <= w_last_g ? S_IDLE : S_LOCKED;
      end else if (r_valid && out_ready) begin
         r_valid   <= 1'b0;
      end
   end

   assign in_ready  = w_ready;
   assign out_data  = r_data;
   assign out_valid = r_valid;
   assign out_last  = r_last;
   assign cur_sel   = r_lock_ch;

endmodule

// File: tb/tb_stream_mux_n.sv
// Randomised and directed bench for stream_mux_n against a
// transaction-level model of the output register and channel lock.
module tb_stream_mux_n;
   localparam int W  = 8;
   localparam int N  = 4;
   localparam int SW = 3;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [SW-1:0]   sel;
   logic [N*W-1:0]  in_data;
   logic [N-1:0]    in_valid;
   logic [N-1:0]    in_last;
   logic [N-1:0]    in_ready;
   logic [W-1:0]    out_data;
   logic            out_valid;
   logic            out_last;
   logic            out_ready;
   logic [SW-1:0]   cur_sel;

   logic [W-1:0]    d_ch [N];

   int checks   = 0;
   int failures = 0;

   // model state
   logic            m_valid;
   logic [W-1:0]    m_data;
   logic            m_last;
   int              m_ch;
   logic            m_locked;
   int              m_g;
   logic [N-1:0]    m_ready;

   stream_mux_n #(.W(W), .N(N), .SW(SW)) dut (
      .clk(clk), .rst_n(rst_n), .sel(sel),
      .in_data(in_data), .in_valid(in_valid),
      .in_last(in_last), .in_ready(in_ready),
      .out_data(out_data), .out_valid(out_valid),
      .out_last(out_last), .out_ready(out_ready),
      .cur_sel(cur_sel)
   );

   always #5 clk = ~clk;

   always_comb begin
      for (int i = 0; i < N; i++) in_data[i*W +: W] = d_ch[i];
   end

   function automatic int exp_g();
      if (m_locked) return m_ch;
`ifdef RR_ARB_EN
      for (int k = 1; k <= N; k++)
         if (in_valid[(m_ch + k) % N]) return (m_ch + k) % N;
      return -1;
`else
      if (int'(sel) < N) return int'(sel);
      return -1;
`endif
   endfunction

   always_comb begin
      m_g = exp_g();
      m_ready = '0;
      if (m_g >= 0 && (!m_valid || out_ready)) m_ready[m_g] = 1'b1;
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_valid  <= 1'b0;
         m_data   <= '0;
         m_last   <= 1'b0;
         m_ch     <= 0;
         m_locked <= 1'b0;
      end else if (m_g >= 0 && m_ready[m_g] && in_valid[m_g]) begin
         m_valid  <= 1'b1;
         m_data   <= d_ch[m_g];
         m_last   <= in_last[m_g];
         m_ch     <= m_g;
         m_locked <= !in_last[m_g];
      end else if (m_valid && out_ready) begin
         m_valid  <= 1'b0;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   always @(negedge clk) begin
      chk("m_out_valid", 32'(out_valid), 32'(m_valid));
      chk("m_out_data",  32'(out_data),  32'(m_data));
      chk("m_out_last",  32'(out_last),  32'(m_last));
      chk("m_cur_sel",   32'(cur_sel),   32'(m_ch));
      chk("m_in_ready",  32'(in_ready),  32'(m_ready));
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in();
      in_valid = '0;
      in_last  = '0;
      for (int i = 0; i < N; i++) d_ch[i] = '0;
   endtask

   initial begin
      rst_n = 1'b0;
      sel = 3'd4;
      out_ready = 1'b0;
      idle_in();
      in_valid = 4'b1111;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_out_data",  32'(out_data),  0);
      chk("rst_cur_sel",   32'(cur_sel),   0);
      chk("rst_in_ready",  32'(in_ready),  0);
      rst_n = 1'b1;
      idle_in();
      cyc();

`ifndef RR_ARB_EN
      // single beat
      sel = 3'd2; out_ready = 1'b1;
      in_valid = 4'b0100; in_last = 4'b0100; d_ch[2] = 8'hA5;
      cyc();
      idle_in();
      chk("single_data",  32'(out_data),  32'hA5);
      chk("single_valid", 32'(out_valid), 1);
      chk("single_sel",   32'(cur_sel),   2);
      sel = 3'd0; #1;
      chk("single_idle_rdy", 32'(in_ready), 32'b0001);
      cyc();

      // packet lock
      sel = 3'd1;
      in_valid = 4'b1010; in_last = 4'b1000;
      d_ch[1] = 8'h10; d_ch[3] = 8'h33;
      cyc();
      chk("lock_b0", 32'(out_data), 32'h10);
      sel = 3'd3; d_ch[1] = 8'h11; #1;
      chk("lock_rdy1", 32'(in_ready), 32'b0010);
      cyc();
      chk("lock_b1", 32'(out_data), 32'h11);
      d_ch[1] = 8'h12; in_last = 4'b1010; #1;
      chk("lock_rdy2", 32'(in_ready), 32'b0010);
      cyc();
      chk("lock_b2", 32'(out_data), 32'h12);
      chk("lock_last", 32'(out_last), 1);
      chk("lock_sel", 32'(cur_sel), 1);
      #1;
      chk("lock_switch_rdy", 32'(in_ready), 32'b1000);
      idle_in();
      cyc();

      // backpressure
      sel = 3'd0;
      in_valid = 4'b0001; in_last = 4'b0001; d_ch[0] = 8'h40;
      cyc();
      out_ready = 1'b0; d_ch[0] = 8'h41;
      for (int k = 0; k < 4; k++) begin
         cyc();
         chk("bp_data",  32'(out_data),  32'h40);
         chk("bp_valid", 32'(out_valid), 1);
         chk("bp_rdy",   32'(in_ready),  0);
      end
      out_ready = 1'b1; #1;
      chk("bp_release_rdy", 32'(in_ready), 32'b0001);
      cyc();
      chk("bp_next", 32'(out_data), 32'h41);
      idle_in();
      cyc();

      // full throughput
      for (int k = 0; k < 16; k++) begin
         in_valid = 4'b0001;
         in_last  = (k == 15) ? 4'b0001 : 4'b0000;
         d_ch[0]  = 8'(8'h80 + k);
         cyc();
         chk("tp_valid", 32'(out_valid), 1);
         chk("tp_data",  32'(out_data),  32'(8'h80 + k));
      end
      idle_in();
      cyc();
`else
      out_ready = 1'b1;
      in_valid = 4'b1111; in_last = 4'b1111;
      for (int i = 0; i < N; i++) d_ch[i] = 8'(i);
      for (int k = 0; k < 6; k++) begin
         cyc();
         chk("rr_order", 32'(cur_sel), 32'((k + 1) % N));
      end
      idle_in();
      cyc();
`endif

      // random traffic
      for (int k = 0; k < 3000; k++) begin
         in_valid  = N'($urandom);
         in_last   = N'($urandom);
         sel       = SW'($urandom_range(0, 7));
         out_ready = ($urandom_range(0, 3) != 0);
         for (int i = 0; i < N; i++) d_ch[i] = W'($urandom);
         cyc();
      end

      // reset mid-packet
      out_ready = 1'b1; sel = 3'd1;
      in_valid = 4'b0010; in_last = 4'b0000; d_ch[1] = 8'h5A;
      cyc();
      chk("mid_pre_valid", 32'(out_valid), 1);
      rst_n = 1'b0; sel = 3'd4; in_valid = 4'b1111; #1;
      chk("mid_rst_valid", 32'(out_valid), 0);
      chk("mid_rst_data",  32'(out_data),  0);
      chk("mid_rst_sel",   32'(cur_sel),   0);
      chk("mid_rst_rdy",   32'(in_ready),  0);
      cyc();
      rst_n = 1'b1; idle_in();
      cyc();
      cyc();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
